// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter fed by a small byte FIFO; a free-running divider
// produces the 16x oversample tick that paces every bit.
module uart_tx_fifo #(
  parameter int unsigned DBIT    = 8,
  parameter int unsigned SB_TICK = 16,
  parameter int unsigned CLK_DIV = 651,
  parameter int unsigned FIFO_AW = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_uart,
  input  logic [7:0] w_data,
  output logic       tx_full,
  output logic       tx_busy,
  output logic       tx
);

  localparam int unsigned CW    = $clog2(CLK_DIV);
  localparam int unsigned DEPTH = 2 ** FIFO_AW;
  localparam int unsigned TW    = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
  localparam int unsigned BW    = (DBIT > 1) ? $clog2(DBIT) : 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic [CW-1:0]      div_q;
  logic               s_tick;
  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wptr_q, rptr_q;
  logic               full_q, empty_q;
  logic               push, pop;
  state_t             state_q, state_n;
  logic [TW-1:0]      tick_q, tick_n;
  logic [BW-1:0]      bit_q, bit_n;
  logic [DBIT-1:0]    shift_q, shift_n;
  logic               tx_q, tx_n;
  logic               busy_q;

  // Oversample tick: not realigned to frame start, so start bits may be up to one tick short.
  assign s_tick = (div_q == CW'(CLK_DIV - 1));

  always_ff @(posedge clk) begin
    if (!rst_n)      div_q <= '0;
    else if (s_tick) div_q <= '0;
    else             div_q <= div_q + CW'(1);
  end

  // A write while full is dropped even when a pop frees a slot in the same cycle.
  assign push = wr_uart && !full_q;

  always_ff @(posedge clk) begin
    if (rst_n && push) mem[wptr_q] <= w_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      if (push) wptr_q <= wptr_q + FIFO_AW'(1);
      if (pop)  rptr_q <= rptr_q + FIFO_AW'(1);
      case ({push, pop})
        2'b10: begin
          empty_q <= 1'b0;
          full_q  <= ((wptr_q + FIFO_AW'(1)) == rptr_q);
        end
        2'b01: begin
          full_q  <= 1'b0;
          empty_q <= ((rptr_q + FIFO_AW'(1)) == wptr_q);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      tick_q  <= tick_n;
      bit_q   <= bit_n;
      shift_q <= shift_n;
      tx_q    <= tx_n;
      busy_q  <= (state_n != IDLE);
    end
  end

  always_comb begin
    state_n = state_q;
    tick_n  = tick_q;
    bit_n   = bit_q;
    shift_n = shift_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty_q) begin
          pop     = 1'b1;
          shift_n = DBIT'(mem[rptr_q]);
          tick_n  = '0;
          state_n = START;
        end
      end
      START: begin
        if (s_tick) begin
          if (tick_q == TW'(15)) begin
            tick_n  = '0;
            bit_n   = '0;
            state_n = DATA;
          end else begin
            tick_n = tick_q + TW'(1);
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (tick_q == TW'(15)) begin
            tick_n  = '0;
            shift_n = shift_q >> 1;
            bit_n   = bit_q + BW'(1);
            if (bit_q == BW'(DBIT - 1)) state_n = STOP;
          end else begin
            tick_n = tick_q + TW'(1);
          end
        end
      end
      STOP: begin
        if (s_tick) begin
          if (tick_q == TW'(SB_TICK - 1)) begin
            tick_n  = '0;
            state_n = IDLE;
          end else begin
            tick_n = tick_q + TW'(1);
          end
        end
      end
      default: state_n = IDLE;
    endcase

    // Line level follows the state being entered so tx changes together with the state register.
    case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = shift_n[0];
      default: tx_n = 1'b1;
    endcase
  end

  assign tx      = tx_q;
  assign tx_busy = busy_q;
  assign tx_full = full_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: a fast instance (CLK_DIV=4) for function
// and a real-rate instance (CLK_DIV=651) for the start-bit length.
module tb_uart_tx_fifo;

  logic       clk, rst_n;
  logic       wr_uart, wr2;
  logic [7:0] w_data, w_data2;
  logic       tx_full, tx_busy, tx;
  logic       full2, busy2, tx2;
  int         checks = 0;
  int         passes = 0;
  logic [8:0] rxq [$];

  uart_tx_fifo #(.DBIT(8), .SB_TICK(16), .CLK_DIV(4), .FIFO_AW(2)) dut (
    .clk(clk), .rst_n(rst_n), .wr_uart(wr_uart), .w_data(w_data),
    .tx_full(tx_full), .tx_busy(tx_busy), .tx(tx)
  );

  uart_tx_fifo #(.DBIT(8), .SB_TICK(16), .CLK_DIV(651), .FIFO_AW(2)) dut_baud (
    .clk(clk), .rst_n(rst_n), .wr_uart(wr2), .w_data(w_data2),
    .tx_full(full2), .tx_busy(busy2), .tx(tx2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Line decoder for the fast instance: 64 clks per bit, sampled mid-bit; stores {stop, byte}.
  always begin : rx_monitor
    logic [7:0] b;
    @(negedge clk);
    if (rst_n === 1'b1 && tx === 1'b0) begin
      repeat (32) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        repeat (64) @(negedge clk);
        b[i] = tx;
      end
      repeat (64) @(negedge clk);
      rxq.push_back({tx, b});
    end
  end

  task automatic wait_rx(input int n, input int budget, output bit ok);
    int t = 0;
    while (rxq.size() < n && t < budget) begin
      @(negedge clk);
      t++;
    end
    ok = (rxq.size() >= n);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; wr_uart = 1'b0; w_data = '0; wr2 = 1'b0; w_data2 = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (tx !== 1'b1)      $display("FAIL reset_tx got %b want 1", tx);        else passes++;
    checks++; if (tx_busy !== 1'b0) $display("FAIL reset_busy got %b want 0", tx_busy); else passes++;
    checks++; if (tx_full !== 1'b0) $display("FAIL reset_full got %b want 0", tx_full); else passes++;
    checks++; if (tx2 !== 1'b1)     $display("FAIL reset_tx2 got %b want 1", tx2);      else passes++;
    checks++; if (busy2 !== 1'b0)   $display("FAIL reset_busy2 got %b want 0", busy2);  else passes++;
    checks++; if (full2 !== 1'b0)   $display("FAIL reset_full2 got %b want 0", full2);  else passes++;
  endtask

  task automatic test_idle();
    int bad = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || tx_busy !== 1'b0 || tx_full !== 1'b0) bad++;
    end
    checks++; if (bad != 0) $display("FAIL idle_line bad_cycles %0d want 0", bad); else passes++;
  endtask

  task automatic test_single_byte();
    int  len;
    bit  ok;
    logic [7:0] pat = 8'h55;
    rxq.delete();
    wr_uart = 1'b1; w_data = 8'h55;
    @(negedge clk);
    wr_uart = 1'b0;
    checks++; if (tx_busy !== 1'b0) $display("FAIL single_busy_early got %b want 0", tx_busy); else passes++;
    @(negedge clk);
    checks++; if (tx_busy !== 1'b1) $display("FAIL single_busy_rise got %b want 1", tx_busy); else passes++;
    checks++; if (tx !== 1'b0)      $display("FAIL single_start_level got %b want 0", tx);     else passes++;
    len = 1;
    while (tx === 1'b0 && len < 200) begin @(negedge clk); if (tx === 1'b0) len++; end
    checks++; if (len < 60 || len > 68) $display("FAIL single_start_len got %0d want 64+-4", len); else passes++;
    for (int i = 0; i < 8; i++) begin
      checks++; if (tx !== pat[i]) $display("FAIL single_bit%0d_level got %b want %b", i, tx, pat[i]); else passes++;
      len = 1;
      while (len < 200) begin @(negedge clk); if (tx === pat[i]) len++; else break; end
      checks++; if (len < 60 || len > 68) $display("FAIL single_bit%0d_len got %0d want 64+-4", i, len); else passes++;
    end
    checks++; if (tx !== 1'b1) $display("FAIL single_stop_level got %b want 1", tx); else passes++;
    len = 1;
    while (len < 200) begin @(negedge clk); if (tx_busy === 1'b1 && tx === 1'b1) len++; else break; end
    checks++; if (len < 60 || len > 68) $display("FAIL single_stop_len got %0d want 64+-4", len); else passes++;
    checks++; if (tx_busy !== 1'b0) $display("FAIL single_busy_fall got %b want 0", tx_busy); else passes++;
    wait_rx(1, 200, ok);
    checks++;
    if (!ok) $display("FAIL single_decode timeout got %0d frames want 1", rxq.size());
    else if (rxq[0] !== 9'h155) $display("FAIL single_decode got %h want 155", rxq[0]);
    else passes++;
  endtask

  task automatic test_burst_overflow();
    int t;
    bit ok;
    int bad = 0;
    logic [7:0] exp [5] = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45};
    rxq.delete();
    for (int i = 0; i < 6; i++) begin
      if (i == 5) begin
        checks++; if (tx_full !== 1'b1) $display("FAIL burst_full_after5 got %b want 1", tx_full); else passes++;
      end
      wr_uart = 1'b1; w_data = 8'(8'h41 + i);
      @(negedge clk);
    end
    wr_uart = 1'b0;
    checks++; if (tx_full !== 1'b1) $display("FAIL burst_full_after6 got %b want 1", tx_full); else passes++;
    wait_rx(1, 1000, ok);
    checks++; if (tx_full !== 1'b1) $display("FAIL burst_full_during_first got %b want 1", tx_full); else passes++;
    t = 0;
    while (tx_full === 1'b1 && t < 200) begin @(negedge clk); t++; end
    checks++; if (tx_full !== 1'b0) $display("FAIL burst_full_clear got %b want 0", tx_full); else passes++;
    wait_rx(5, 4000, ok);
    checks++; if (!ok) $display("FAIL burst_frames timeout got %0d want 5", rxq.size()); else passes++;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (rxq.size() <= i) $display("FAIL burst_byte%0d missing want %h", i, exp[i]);
      else if (rxq[i] !== {1'b1, exp[i]}) $display("FAIL burst_byte%0d got %h want %h", i, rxq[i], {1'b1, exp[i]});
      else passes++;
    end
    for (int i = 0; i < 800; i++) begin @(negedge clk); if (tx !== 1'b1) bad++; end
    checks++; if (bad != 0 || rxq.size() != 5) $display("FAIL burst_dropped_46 frames %0d low_cycles %0d want 5/0", rxq.size(), bad); else passes++;
  endtask

  task automatic test_full_write_on_pop();
    int t = 0;
    bit ok;
    int bad = 0;
    logic [7:0] exp [5] = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50};
    rxq.delete();
    for (int i = 0; i < 5; i++) begin
      wr_uart = 1'b1; w_data = exp[i];
      @(negedge clk);
    end
    wr_uart = 1'b0;
    checks++; if (tx_full !== 1'b1) $display("FAIL fullpop_filled got %b want 1", tx_full); else passes++;
    while (tx_busy === 1'b1 && t < 1000) begin @(negedge clk); t++; end
    checks++; if (tx_busy !== 1'b0 || tx_full !== 1'b1) $display("FAIL fullpop_gap busy %b full %b want 0/1", tx_busy, tx_full); else passes++;
    wr_uart = 1'b1; w_data = 8'h99;
    @(negedge clk);
    wr_uart = 1'b0;
    checks++; if (tx_full !== 1'b0 || tx_busy !== 1'b1) $display("FAIL fullpop_after_pop full %b busy %b want 0/1", tx_full, tx_busy); else passes++;
    wait_rx(5, 4000, ok);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (rxq.size() <= i) $display("FAIL fullpop_byte%0d missing want %h", i, exp[i]);
      else if (rxq[i] !== {1'b1, exp[i]}) $display("FAIL fullpop_byte%0d got %h want %h", i, rxq[i], {1'b1, exp[i]});
      else passes++;
    end
    for (int i = 0; i < 800; i++) begin @(negedge clk); if (tx !== 1'b1) bad++; end
    checks++; if (bad != 0 || rxq.size() != 5) $display("FAIL fullpop_no_99 frames %0d low_cycles %0d want 5/0", rxq.size(), bad); else passes++;
  endtask

  task automatic test_reset_mid_frame();
    int bad = 0;
    bit ok;
    rxq.delete();
    wr_uart = 1'b1; w_data = 8'hA3;
    @(negedge clk);
    w_data = 8'h3C;
    @(negedge clk);
    wr_uart = 1'b0;
    repeat (150) @(negedge clk);
    checks++; if (tx_busy !== 1'b1) $display("FAIL midrst_in_frame got %b want 1", tx_busy); else passes++;
    rst_n = 1'b0; wr_uart = 1'b1; w_data = 8'h77;
    @(negedge clk);
    rst_n = 1'b1; wr_uart = 1'b0;
    checks++; if (tx !== 1'b1)      $display("FAIL midrst_tx got %b want 1", tx);        else passes++;
    checks++; if (tx_busy !== 1'b0) $display("FAIL midrst_busy got %b want 0", tx_busy); else passes++;
    checks++; if (tx_full !== 1'b0) $display("FAIL midrst_full got %b want 0", tx_full); else passes++;
    for (int i = 0; i < 700; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || tx_busy !== 1'b0) bad++;
    end
    checks++; if (bad != 0) $display("FAIL midrst_flushed bad_cycles %0d want 0", bad); else passes++;
    rxq.delete();
    wr_uart = 1'b1; w_data = 8'h0F;
    @(negedge clk);
    wr_uart = 1'b0;
    wait_rx(1, 1000, ok);
    repeat (200) @(negedge clk);
    checks++;
    if (!ok || rxq.size() != 1) $display("FAIL midrst_next frames %0d want 1", rxq.size());
    else if (rxq[0] !== 9'h10F) $display("FAIL midrst_next got %h want 10f", rxq[0]);
    else passes++;
  endtask

  task automatic test_baud();
    int len;
    int bad = 0;
    wr2 = 1'b1; w_data2 = 8'hFF;
    @(negedge clk);
    wr2 = 1'b0;
    @(negedge clk);
    checks++; if (busy2 !== 1'b1 || tx2 !== 1'b0) $display("FAIL baud_start busy %b tx %b want 1/0", busy2, tx2); else passes++;
    len = 1;
    while (len < 12000) begin @(negedge clk); if (tx2 === 1'b0) len++; else break; end
    checks++; if (len < 9765 || len > 11067) $display("FAIL baud_start_len got %0d want 10416+-651", len); else passes++;
    for (int i = 0; i < 31248; i++) begin
      @(negedge clk);
      if (tx2 !== 1'b1 || busy2 !== 1'b1) bad++;
    end
    checks++; if (bad != 0) $display("FAIL baud_high_data bad_cycles %0d want 0", bad); else passes++;
  endtask

  initial begin
    test_reset();
    test_idle();
    test_single_byte();
    test_burst_overflow();
    test_full_write_on_pop();
    test_reset_mid_frame();
    test_baud();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
